// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA raster path.
//   color_t    : {R,G,B} colour as produced by the shape generators
//   pix_t      : registered pixel payload driven onto the connector
//   below()    : unsigned "v < lim" on a COORD_W-bit coordinate
//   in_window(): unsigned "lo <= v < hi" on a COORD_W-bit coordinate
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  typedef logic [2:0] color_t;

  localparam color_t COLOR_BLACK = 3'b000;
  localparam color_t COLOR_RED   = 3'b100;
  localparam color_t COLOR_WHITE = 3'b111;
  localparam color_t COLOR_BLUE  = 3'b001;

  // Default 640x480@60 timing (25 MHz pixel rate).
  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    color_t rgb;
    logic   active;
    logic   hsync;
    logic   vsync;
  } pix_t;

  localparam pix_t PIX_RESET = '{rgb: COLOR_BLACK, active: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // One extra bit so a bound equal to 2**COORD_W still compares correctly.
  function automatic logic below(input logic [COORD_W-1:0] v, input int unsigned lim);
    return {1'b0, v} < (COORD_W+1)'(lim);
  endfunction

  function automatic logic in_window(input logic [COORD_W-1:0] v, input int unsigned lo,
                                     input int unsigned hi);
    return !below(v, lo) && below(v, hi);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MAX up-counter used for the horizontal and vertical raster counts.
//   clk, n_rst : clock, async active-low reset (count -> 0)
//   inc        : advance by one this clk
//   count      : current value, 0..MAX-1
//   wrap       : high on the clk where count goes MAX-1 -> 0
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int unsigned MAX = 800
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               inc,
  output logic [COORD_W-1:0] count,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] LAST = COORD_W'(MAX - 1);

  logic at_last;

  assign at_last = (count == LAST);
  assign wrap    = inc && at_last;

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (inc) begin
      count <= at_last ? '0 : count + COORD_W'(1);
    end
  end

endmodule

// File: rtl/vga_pixel_driver.sv
// VGA raster/timing stage: generates pixel coordinates for the shape blocks and
// registers their colour, blanked, together with hsync/vsync on the pixel tick.
//   clk, n_rst         : system clock, async active-low reset
//   en                 : run enable; low suppresses the pixel tick
//   shape_color        : {R,G,B} from the shape generator for the current x/y
//   x, y               : current hcount/vcount (straight from the counters)
//   red, green, blue   : blanked colour of the previous pixel
//   hsync, vsync       : active-low syncs aligned with the colour
//   active             : pixel on rgb lies inside the visible area
//   frame_start        : one-clk pulse when pixel (0,0) reaches rgb
module vga_pixel_driver
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               en,
  input  color_t             shape_color,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               red,
  output logic               green,
  output logic               blue,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;
  logic               h_wrap;
  logic               v_inc;
  logic               v_wrap;
  logic               at_origin;
  logic               vis;
  pix_t               pix_next;
  pix_t               pix_q;

  // Pixel-rate divider; holds its phase while en is low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign tick  = en && (div == DIV_LAST);
  assign v_inc = tick && h_wrap;

  vga_wrap_counter #(.MAX(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (tick),
    .count (hcount),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(.MAX(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (v_inc),
    .count (vcount),
    .wrap  (v_wrap)
  );

  assign x = hcount;
  assign y = vcount;

  // Blanking and sync decode of the current (pre-increment) position.
  always_comb begin
    pix_next = PIX_RESET;
    vis      = below(hcount, H_ACTIVE) && below(vcount, V_ACTIVE);
    pix_next.rgb    = vis ? shape_color : COLOR_BLACK;
    pix_next.active = vis;
    pix_next.hsync  = !in_window(hcount, HS_START, HS_END);
    pix_next.vsync  = !in_window(vcount, VS_START, VS_END);
  end

  // Output stage. at_origin tracks "counters sit at (0,0)" so frame_start
  // needs no wide compare: it is set at reset and by a full-frame wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_q       <= PIX_RESET;
      at_origin   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && at_origin;
      if (tick) begin
        pix_q     <= pix_next;
        at_origin <= v_wrap;
      end
    end
  end

  assign red    = pix_q.rgb[2];
  assign green  = pix_q.rgb[1];
  assign blue   = pix_q.rgb[0];
  assign active = pix_q.active;
  assign hsync  = pix_q.hsync;
  assign vsync  = pix_q.vsync;

endmodule
